// File: rtl/uart_rx_sampler_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler_pkg
// Shared definitions for the UART receive path:
//   - receiver state encoding
//   - log2 helper (bit count of a value)
//   - phase-accumulator width/increment computation used by the oversampling
//     tick generator (same arithmetic as the transmitter baud generator)
// -----------------------------------------------------------------------------
package uart_rx_sampler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Number of bits needed to represent v (log2(8) = 4, log2(7) = 3).
    function automatic int log2(input longint v);
        int     n;
        longint t;
        n = 0;
        t = v;
        while (t > 0) begin
            n++;
            t = t >> 1;
        end
        return n;
    endfunction

    // Accumulator width: 8 fractional bits beyond the integer clock/rate ratio.
    function automatic int acc_width(input longint clk_hz, input longint rate_hz);
        return log2(clk_hz / rate_hz) + 8;
    endfunction

    // Increment such that the accumulator carry fires at rate_hz.
    // Pre-scaling by 2^7 / 2^8 keeps the intermediate product in range and
    // rounds to nearest.
    function automatic longint acc_inc(input longint clk_hz, input longint rate_hz,
                                       input int width);
        return ((rate_hz << (width - 7)) + (clk_hz >> 8)) / (clk_hz >> 7);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_os_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_os_tick_gen
// Free-running phase accumulator producing a one-clock pulse at
// Baud*Oversampling. Never gated: the receiver relies on a continuous tick.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (clears accumulator)
//   tick  out  one-clock pulse at the oversampling rate
// -----------------------------------------------------------------------------
module uart_os_tick_gen
    import uart_rx_sampler_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam longint RateHz = longint'(Baud) * longint'(Oversampling);
    localparam int     AccW   = acc_width(longint'(ClkFrequency), RateHz);
    localparam logic [AccW:0] AccInc =
        (AccW + 1)'(acc_inc(longint'(ClkFrequency), RateHz, AccW));

    // Extra MSB holds the carry; it is cleared on the next add so it pulses.
    logic [AccW:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= {1'b0, r_acc[AccW-1:0]} + AccInc;
        end
    end

    assign tick = r_acc[AccW];

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// 8N1 UART receiver (LSB first, idle high). Oversamples RxD, validates the
// start bit at its middle, majority-filters the line, shifts in 8 data bits
// and checks the stop bit.
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   RxD             in   serial line, asynchronous to clk
//   RxD_data        out  last correctly received byte
//   RxD_data_ready  out  one-clock pulse when RxD_data updates
//   RxD_frame_err   out  one-clock pulse when the stop bit samples 0
//   RxD_idle        out  high while the receiver is in IDLE
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_rx_sampler_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_idle
);

    localparam int OsW     = log2(longint'(Oversampling - 1));
    localparam int OsLastI = Oversampling - 1;
    localparam int OsHalfI = Oversampling / 2 - 1;
    localparam logic [OsW-1:0] OsLast = OsW'(OsLastI);
    localparam logic [OsW-1:0] OsHalf = OsW'(OsHalfI);

    generate
        if (Oversampling < 4 || (Oversampling & (Oversampling - 1)) != 0) begin : g_bad_os
            $error("Oversampling must be a power of two and at least 4");
        end
    endgenerate

    logic            w_tick;
    logic            r_sync1;
    logic            r_sync2;
    logic [2:0]      r_hist;
    logic            r_filt;

    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic [OsW-1:0]  r_os_cnt;
    logic [OsW-1:0]  w_os_cnt_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;

    logic            w_ready_set;
    logic            w_ferr_set;
    logic [7:0]      r_data;
    logic            r_ready;
    logic            r_ferr;

    uart_os_tick_gen #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (Oversampling)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Synchronizer and majority filter. Flops reset high so a reset never
    // looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 3'b111;
            r_filt  <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_hist <= {r_hist[1:0], r_sync2};
            end
            r_filt <= (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) |
                      (r_hist[1] & r_hist[2]);
        end
    end

    // State register (with counters and shift register that move with it)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_os_cnt  <= w_os_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next-state logic; everything advances only on oversampling ticks.
    always_comb begin
        w_state_nxt   = r_state;
        w_os_cnt_nxt  = r_os_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!r_filt) begin
                        w_state_nxt  = START;
                        w_os_cnt_nxt = '0;
                    end
                end
                START: begin
                    if (r_os_cnt == OsHalf) begin
                        // Line back high at mid start bit: it was a glitch.
                        if (r_filt) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt   = DATA;
                            w_os_cnt_nxt  = '0;
                            w_bit_idx_nxt = '0;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + OsW'(1);
                    end
                end
                DATA: begin
                    if (r_os_cnt == OsLast) begin
                        w_shift_nxt   = {r_filt, r_shift[7:1]};
                        w_os_cnt_nxt  = '0;
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            w_state_nxt = STOP;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + OsW'(1);
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is seen.
                    if (r_os_cnt == OsLast) begin
                        w_os_cnt_nxt = '0;
                        w_state_nxt  = r_filt ? IDLE : BREAK;
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + OsW'(1);
                    end
                end
                BREAK: begin
                    if (r_filt) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output decode: stop-bit verdict is mutually exclusive by construction.
    always_comb begin
        w_ready_set = 1'b0;
        w_ferr_set  = 1'b0;
        if (w_tick && r_state == STOP && r_os_cnt == OsLast) begin
            w_ready_set = r_filt;
            w_ferr_set  = ~r_filt;
        end
        RxD_idle = (r_state == IDLE);
    end

    // Registered outputs; data and its ready pulse appear on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ready <= w_ready_set;
            r_ferr  <= w_ferr_set;
            if (w_ready_set) begin
                r_data <= r_shift;
            end
        end
    end

    assign RxD_data       = r_data;
    assign RxD_data_ready = r_ready;
    assign RxD_frame_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;

    localparam int CLK_HZ  = 50000000;
    localparam int BAUD    = 115200;
    localparam int OS      = 8;
    localparam int BIT_CLK = 434;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_err;
    logic       RxD_idle;

    always #5 clk = ~clk;

    uart_rx_sampler #(
        .ClkFrequency (CLK_HZ),
        .Baud         (BAUD),
        .Oversampling (OS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RxD            (RxD),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_frame_err  (RxD_frame_err),
        .RxD_idle       (RxD_idle)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         ready_times[$];
    int         checks = 0;
    int         passes = 0;
    int         cyc    = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Monitor: every output pulse consumes one expected frame outcome.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && (RxD_data_ready || RxD_frame_err)) begin
            check("ready_ferr_exclusive", {31'd0, RxD_data_ready & RxD_frame_err}, 32'd0);
            if (RxD_data_ready) ready_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: ready=%0b ferr=%0b data=%0h with no frame pending",
                         RxD_data_ready, RxD_frame_err, RxD_data);
            end else begin
                e = exp_q.pop_front();
                check("outcome_is_err", {31'd0, RxD_frame_err}, {31'd0, e.is_err});
                check("rx_data", {24'd0, RxD_data}, {24'd0, e.data});
                if (RxD_data_ready) check("idle_at_ready", {31'd0, RxD_idle}, 32'd1);
            end
        end
    end

    // Reference model: a frame with stop=1 delivers its byte; with stop=0 it
    // reports a framing error and the output keeps the last good byte.
    task automatic send(input logic [7:0] b, input logic stopv, input int per);
        exp_t x;
        if (stopv) begin
            x.is_err = 1'b0; x.data = b; last_good = b;
        end else begin
            x.is_err = 1'b1; x.data = last_good;
        end
        exp_q.push_back(x);
        RxD = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (per) @(negedge clk);
        end
        RxD = stopv;
        repeat (per) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         gap;

        // Reset state
        rst = 1'b1;
        RxD = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", {24'd0, RxD_data}, 32'h00);
        check("rst_ready", {31'd0, RxD_data_ready}, 32'd0);
        check("rst_ferr", {31'd0, RxD_frame_err}, 32'd0);
        check("rst_idle", {31'd0, RxD_idle}, 32'd1);
        rst = 1'b0;
        repeat (BIT_CLK) @(negedge clk);

        // Single byte
        send(8'h55, 1'b1, BIT_CLK);
        wait_drain("drain_55", 4 * BIT_CLK);
        check("idle_after_55", {31'd0, RxD_idle}, 32'd1);

        // Back-to-back frames, no gap
        ready_times.delete();
        send(8'hA5, 1'b1, BIT_CLK);
        send(8'h3C, 1'b1, BIT_CLK);
        wait_drain("drain_b2b", 4 * BIT_CLK);
        check("b2b_pulse_count", ready_times.size(), 32'd2);
        if (ready_times.size() == 2) begin
            gap = ready_times[1] - ready_times[0];
            check("b2b_gap_in_range", {31'd0, (gap >= 4280 && gap <= 4400)}, 32'd1);
        end

        // Framing error then held-low line
        send(8'h00, 1'b0, BIT_CLK);
        RxD = 1'b0;
        repeat (20 * BIT_CLK) @(negedge clk);
        check("break_not_idle", {31'd0, RxD_idle}, 32'd0);
        check("break_data_kept", {24'd0, RxD_data}, {24'd0, last_good});
        RxD = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("idle_after_break", {31'd0, RxD_idle}, 32'd1);
        wait_drain("drain_ferr", 4 * BIT_CLK);
        send(8'h7E, 1'b1, BIT_CLK);
        wait_drain("drain_7e", 4 * BIT_CLK);

        // Glitches on idle line
        RxD = 1'b0;
        repeat (54) @(negedge clk);
        RxD = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("idle_after_tick_glitch", {31'd0, RxD_idle}, 32'd1);
        RxD = 1'b0;
        repeat (40) @(negedge clk);
        RxD = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("idle_after_40clk_glitch", {31'd0, RxD_idle}, 32'd1);

        // Reset during bit 4 of 0xF0
        rb  = 8'hF0;
        RxD = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RxD = rb[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        RxD = rb[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check("midrst_data", {24'd0, RxD_data}, 32'h00);
        check("midrst_ready", {31'd0, RxD_data_ready}, 32'd0);
        check("midrst_ferr", {31'd0, RxD_frame_err}, 32'd0);
        check("midrst_idle", {31'd0, RxD_idle}, 32'd1);
        rst = 1'b0;
        RxD = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("post_rst_data", {24'd0, RxD_data}, 32'h00);
        send(8'h81, 1'b1, BIT_CLK);
        wait_drain("drain_81", 4 * BIT_CLK);

        // Baud mismatch +3% / -3%
        send(8'hC3, 1'b1, 421);
        RxD = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        send(8'hC3, 1'b1, 447);
        wait_drain("drain_c3", 4 * BIT_CLK);

        // Randomized frames
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send(rb, rs, $urandom_range(428, 440));
            RxD = 1'b1;
            repeat (rs ? $urandom_range(0, 300) : 2 * BIT_CLK) @(negedge clk);
        end
        wait_drain("drain_random", 6 * BIT_CLK);

        repeat (2 * BIT_CLK) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
